decoder_scan_ctrl: RTL and testbench
====================================

# decoder_scan_ctrl

Round-robin channel scanner that sits directly upstream of the 2:4 decoder. It drives the decoder's active-low enable (`en`) and 2-bit select (`a` = MSB, `b` = LSB). It steps through the unmasked channels of a 4-channel group and holds each channel selected for a programmable dwell. Between channels it inserts a fixed blanking gap with `en` deasserted, so two decoder outputs are never low in adjacent cycles. Typical uses are display-digit multiplexing and time-sliced peripheral select.

## Interface
- `DWELL_W`, default 8: width of the dwell input.
- `BLANK_CYCLES`, default 2: cycles with `en`=1 between windows; 0 is legal and means no gap.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `run`, input, 1: scan enable, level-sensitive.
- `mask`, input, 4: per-channel enable; bit k=1 means channel k is scanned.
- `dwell`, input, DWELL_W: active window length is `dwell`+1 cycles.
- `en`, output, 1: decoder enable, active-low; registered.
- `a`, output, 1: channel index MSB; registered.
- `b`, output, 1: channel index LSB; registered.
- `chan_strobe`, output, 1: one-cycle pulse in the first cycle of every active window.
- `frame_done`, output, 1: one-cycle pulse, coincident with `chan_strobe`, when the scan has wrapped.

## Operation
- Channel index k = {a,b}. With `en`=0 the decoder drives output k low; for example, channel 2 gives 1011.
- FSM states: IDLE, ACTIVE, BLANK.
- Reset values and behaviour:
  - Outputs: `en`=1, `a`=0, `b`=0, `chan_strobe`=0, `frame_done`=0.
  - State IDLE; dwell and blank counters cleared.
  - Reset mid-operation aborts the window at the next edge with no completion.
- IDLE:
  - `en`=1; `a` and `b` hold their last value.
  - If `run`=1 and `mask`≠0 at an edge, go to ACTIVE. Select the lowest set mask bit, searching from channel 0.
  - On that edge, load the dwell counter with `dwell` and pulse `chan_strobe`.
  - `frame_done` is not asserted on a start from IDLE.
- ACTIVE:
  - `en`=0 with `a`,`b` stable for `dwell`+1 cycles; the counter decrements to 0.
  - At count 0, if `BLANK_CYCLES`>0: go to BLANK, drive `en`=1, hold `a`,`b`, load the blank counter with `BLANK_CYCLES`-1.
  - At count 0, if `BLANK_CYCLES`=0: apply the BLANK exit rule directly.
- BLANK exit rule, applied when the blank counter reaches 0:
  - If `run`=1 and `mask`≠0: search for the next set mask bit starting at current+1, modulo 4. Go to ACTIVE, reload dwell, pulse `chan_strobe`.
  - Pulse `frame_done` if the new index is ≤ the previous index. This includes the single-channel case, where the same channel is reselected.
  - Otherwise go to IDLE with `en`=1.
- Sampling rules:
  - `mask` is sampled only at channel selection; `dwell` only at window start. Changes mid-window have no effect on the current window.
  - Deasserting `run` mid-window finishes the current window and its blank, then enters IDLE. The window is never truncated.
  - A masked-off current channel still completes its window.
- Glitch-free guarantee: `a` and `b` change only on an edge where `en` goes from 1 to 0, or on an ACTIVE-to-ACTIVE handoff when `BLANK_CYCLES`=0. They never change while `en`=0 within a window.

## Timing
- Start latency: `run` sampled high at edge E gives `en`=0 and the first `chan_strobe` at the outputs immediately after E.
- Channel period = `dwell`+1+`BLANK_CYCLES` cycles. Frame period = (number of set mask bits) × channel period.
- Stop: after `run` falls, `en` returns to 1 within at most `dwell`+1 cycles, and the FSM reaches IDLE after a further `BLANK_CYCLES` cycles.
- No combinational path from any input to any output.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `run`=1, `mask`=1111.
  - Required: `en`=1, `a`=`b`=0, both strobes 0 throughout.
  - Release: first window is channel 0 one cycle after the first edge with `rst_n`=1.
- **Full scan:** `mask`=1111, `dwell`=3, `BLANK_CYCLES`=2, `run`=1.
  - Required: channels 0,1,2,3,0 in order; each has 4 cycles of `en`=0 followed by 2 cycles of `en`=1.
  - Decoder outputs: 1110, 1101, 1011, 0111.
  - `frame_done` only on the second channel-0 strobe (cycle 24 after start).
- **Sparse mask:** `mask`=1010.
  - Required: sequence 1,3,1,3; `frame_done` on every channel-1 strobe except the first.
- **Stop mid-window:** deassert `run` in cycle 2 of the channel-2 window, `dwell`=3.
  - Required: `en`=0 stays low until 4 cycles total, then 2 blank cycles, then IDLE with `en`=1 held and no further strobes.
- **Reset mid-window:** pull `rst_n` low during ACTIVE on channel 3.
  - Required: next edge gives `en`=1, `a`=`b`=0; after release the scan restarts at the lowest set channel.
- **Edge cases:** `dwell`=0, `mask`=0100.
  - Required: `en` low for 1 cycle every 3 cycles; `frame_done` with every strobe after the first.
  - Then set `mask`=0000: FSM enters IDLE after the current blank.

Source files
------------

// File: rtl/decoder_scan_if.sv
// Scanner-to-host bundle for decoder_scan_ctrl.
// master : drives run / mask / dwell, observes the decoder drive and strobes.
// slave  : the scanner itself.
//   run         scan enable (level)
//   mask[3:0]   per-channel enable, bit k = channel k scanned
//   dwell       active window length minus one
//   en          decoder enable, active-low
//   a, b        channel index MSB / LSB
//   chan_strobe first cycle of every active window
//   frame_done  coincident with chan_strobe when the scan wrapped
interface decoder_scan_if #(
  parameter int DWELL_W = 8
);
  logic               run;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               en;
  logic               a;
  logic               b;
  logic               chan_strobe;
  logic               frame_done;

  modport master (
    output run, mask, dwell,
    input  en, a, b, chan_strobe, frame_done
  );

  modport slave (
    input  run, mask, dwell,
    output en, a, b, chan_strobe, frame_done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Round-robin channel scanner feeding a 2:4 decoder.
// Steps through the unmasked channels, holding each one selected (en low)
// for dwell+1 cycles, then inserts BLANK_CYCLES cycles with en high.
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous reset, active-low
//   bus    decoder_scan_if slave (run, mask, dwell in; en, a, b, strobes out)
// All outputs are registered.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | not scanning, en high, a/b hold last channel
// S_ACTIVE | window open, en low, dwell counter running down
// S_BLANK  | gap between windows, en high, blank counter running down
module decoder_scan_ctrl #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);

  localparam int BW = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LOAD =
    BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] dcnt;
  logic [BW-1:0]      bcnt;
  logic [1:0]         sel;
  logic               en_q;
  logic               strobe_q;
  logic               frame_q;

  logic               go;
  logic               handoff;
  logic [1:0]         first_chan;
  logic [1:0]         next_sel;

  // First set bit of m at or after start, wrapping modulo 4.
  function automatic logic [1:0] next_chan(input logic [3:0] m,
                                           input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    next_chan = start;
    found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && m[idx]) begin
        next_chan = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign go         = bus.run && (bus.mask != 4'd0);
  assign first_chan = next_chan(bus.mask, 2'd0);
  assign next_sel   = next_chan(bus.mask, sel + 2'd1);

  // End of a channel period: blank expired, or window expired with no gap.
  assign handoff = ((state == S_BLANK) && (bcnt == '0)) ||
                   ((state == S_ACTIVE) && (dcnt == '0) && (BLANK_CYCLES == 0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dcnt     <= '0;
      bcnt     <= '0;
      sel      <= 2'd0;
      en_q     <= 1'b1;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          en_q <= 1'b1;
          if (go) begin
            state    <= S_ACTIVE;
            sel      <= first_chan;
            en_q     <= 1'b0;
            dcnt     <= bus.dwell;
            strobe_q <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (dcnt != '0) begin
            dcnt <= dcnt - 1'b1;
          end else if (BLANK_CYCLES != 0) begin
            state <= S_BLANK;
            en_q  <= 1'b1;
            bcnt  <= BLANK_LOAD;
          end
        end
        S_BLANK: begin
          if (bcnt != '0) bcnt <= bcnt - 1'b1;
        end
        default: begin
          state <= S_IDLE;
          en_q  <= 1'b1;
        end
      endcase

      if (handoff) begin
        if (go) begin
          state    <= S_ACTIVE;
          sel      <= next_sel;
          en_q     <= 1'b0;
          dcnt     <= bus.dwell;
          strobe_q <= 1'b1;
          // Wrap includes reselecting the same single channel.
          frame_q  <= (next_sel <= sel);
        end else begin
          state <= S_IDLE;
          en_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.en          = en_q;
  assign bus.a           = sel[1];
  assign bus.b           = sel[0];
  assign bus.chan_strobe = strobe_q;
  assign bus.frame_done  = frame_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] mask;
  logic [7:0] dwell;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_scan_if #(.DWELL_W(8)) bus0 ();
  decoder_scan_if #(.DWELL_W(8)) bus1 ();

  assign bus0.run   = run;
  assign bus0.mask  = mask;
  assign bus0.dwell = dwell;
  assign bus1.run   = run;
  assign bus1.mask  = mask;
  assign bus1.dwell = dwell;

  decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Reference model: time since window start against the channel period.
  int blk [2] = '{2, 0};
  bit m_busy [2];
  int m_t    [2];
  int m_dw   [2];
  int m_cur  [2];
  int e_en   [2];
  int e_cs   [2];
  int e_fd   [2];

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int first_set(input logic [3:0] m, input int from);
    int r;
    r = from % 4;
    for (int k = 0; k < 4; k++) begin
      if (m[(from + k) % 4]) begin
        r = (from + k) % 4;
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] dec(input logic en, input logic a, input logic b);
    logic [3:0] one;
    one = 4'b0001;
    return en ? 4'b1111 : ~(one << {a, b});
  endfunction

  task automatic model_update();
    int per, nw;
    for (int n = 0; n < 2; n++) begin
      e_cs[n] = 0;
      e_fd[n] = 0;
      if (!rst_n) begin
        m_busy[n] = 0;
        m_cur[n]  = 0;
        e_en[n]   = 1;
      end else if (!m_busy[n]) begin
        e_en[n] = 1;
        if (run && mask != 4'd0) begin
          m_busy[n] = 1;
          m_cur[n]  = first_set(mask, 0);
          m_t[n]    = 0;
          m_dw[n]   = int'(dwell);
          e_en[n]   = 0;
          e_cs[n]   = 1;
        end
      end else begin
        m_t[n]++;
        per = m_dw[n] + 1 + blk[n];
        if (m_t[n] < per) begin
          e_en[n] = (m_t[n] <= m_dw[n]) ? 0 : 1;
        end else if (run && mask != 4'd0) begin
          nw        = first_set(mask, m_cur[n] + 1);
          e_fd[n]   = (nw <= m_cur[n]) ? 1 : 0;
          m_cur[n]  = nw;
          m_t[n]    = 0;
          m_dw[n]   = int'(dwell);
          e_en[n]   = 0;
          e_cs[n]   = 1;
        end else begin
          m_busy[n] = 0;
          e_en[n]   = 1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("en0",  int'(bus0.en),            e_en[0]);
    chk("sel0", int'({bus0.a, bus0.b}),   m_cur[0]);
    chk("cs0",  int'(bus0.chan_strobe),   e_cs[0]);
    chk("fd0",  int'(bus0.frame_done),    e_fd[0]);
    chk("en1",  int'(bus1.en),            e_en[1]);
    chk("sel1", int'({bus1.a, bus1.b}),   m_cur[1]);
    chk("cs1",  int'(bus1.chan_strobe),   e_cs[1]);
    chk("fd1",  int'(bus1.frame_done),    e_fd[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  logic [3:0] exp_dec [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    bit found;
    m_busy = '{0, 0};
    m_cur  = '{0, 0};

    // Reset held with run and full mask.
    rst_n = 1'b0;
    run   = 1'b1;
    mask  = 4'b1111;
    dwell = 8'd3;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // Full scan, then stop in cycle 2 of the second channel-2 window.
    for (int c = 0; c < 50; c++) begin
      step();
      if (c < 24 && (c % 6) == 0)
        chk("full_dec", int'(dec(bus0.en, bus0.a, bus0.b)), int'(exp_dec[c / 6]));
      if (c <= 24)
        chk("full_fd", int'(bus0.frame_done), (c == 24) ? 1 : 0);
      if (c == 37) run = 1'b0;
      if (c >= 38 && c <= 39) chk("stop_hold", int'(bus0.en), 0);
      if (c >= 40) begin
        chk("stop_en", int'(bus0.en), 1);
        chk("stop_cs", int'(bus0.chan_strobe), 0);
      end
    end

    // Reset while channel 3 is active.
    run   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus0.en == 1'b0 && {bus0.a, bus0.b} == 2'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("find_ch3", int'(found), 1);
    rst_n = 1'b0;
    step();
    chk("rst_mid_en",  int'(bus0.en), 1);
    chk("rst_mid_sel", int'({bus0.a, bus0.b}), 0);
    rst_n = 1'b1;

    // Sparse mask: restart at lowest set channel.
    mask = 4'b1010;
    step();
    chk("sparse_start", int'({bus0.a, bus0.b}), 1);
    for (int i = 0; i < 40; i++) step();

    // Single channel, minimum dwell, then mask cleared.
    dwell = 8'd0;
    mask  = 4'b0100;
    for (int i = 0; i < 24; i++) step();
    mask = 4'b0000;
    for (int i = 0; i < 8; i++) step();
    chk("mask0_idle", int'(bus0.en), 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mask = 4'($urandom_range(0, 15));
      dwell = 8'($urandom_range(0, 5));
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
